// File: rtl/face_pkg.sv
// Shared definitions for the face-detection pixel pipeline.
// Holds the frame-buffer state enum, default image geometry,
// the default pixel count N_PIX and the coordinate width.
package face_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_FULL = 2'd1,
      ST_PLAY = 2'd2
   } state_t;

   localparam int DEF_IMG_WIDTH  = 256;
   localparam int DEF_IMG_HEIGHT = 256;
   localparam int DEF_DEPTH      = 8;
   localparam int N_PIX          = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
   localparam int COORD_W        = 9;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// The read register only updates when i_re is high, so the output holds
// its last value between reads. Contents are not reset; only the read
// register is.
// Ports:
//   clk, rst          clock, async active-high reset (read register only)
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr           read request / address
//   o_rdata                registered read data (1-cycle latency)
module frame_ram #(
   parameter int DW    = 24,
   parameter int WORDS = 65536,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [WORDS];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/rgb_frame_buffer.sv
// Captures one raster-order RGB frame, then replays it with x/y coordinates.
// LOAD: pixels written while enable=1. FULL: waits for enable_process.
// PLAY: streams N pixels, one per cycle, then pulses done and returns to LOAD.
// Optional macro FRAME_CHECKSUM_EN adds output checksum = sum of R+G+B of
// all accepted pixels (cleared by reset and on LOAD entry).
// Ports:
//   clk, rst               clock, async active-high reset
//   in_r/in_g/in_b, enable  pixel load interface
//   enable_process          replay request (level)
//   frame_full              frame stored
//   out_r/g/b, out_x/out_y  replayed pixel and coordinates (valid with finish)
//   finish, done            replay valid / end-of-replay pulse
//   checksum                (FRAME_CHECKSUM_EN only)
module rgb_frame_buffer
   import face_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DEPTH-1:0]   in_r,
   input  logic [DEPTH-1:0]   in_g,
   input  logic [DEPTH-1:0]   in_b,
   input  logic               enable,
   input  logic               enable_process,
   output logic               frame_full,
   output logic [DEPTH-1:0]   out_r,
   output logic [DEPTH-1:0]   out_g,
   output logic [DEPTH-1:0]   out_b,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic               finish,
   output logic               done
`ifdef FRAME_CHECKSUM_EN
   ,output logic [DEPTH+ADDR_W+1:0] checksum
`endif
);

   localparam int N = IMG_WIDTH * IMG_HEIGHT;

   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_wr_cnt, r_rd_cnt;
   logic [COORD_W-1:0]  r_x, r_y;      // coordinates of the address being issued
   logic                r_last;        // last address issued; next cycle closes PLAY
   logic                w_wr, w_wr_last, w_rd, w_rd_last, w_play_start, w_play_end;
   logic [3*DEPTH-1:0]  w_rdata;

   assign w_wr         = (r_state == ST_LOAD) && enable;
   assign w_wr_last    = w_wr && (r_wr_cnt == ADDR_W'(N-1));
   assign w_play_start = (r_state == ST_FULL) && enable_process;
   assign w_rd         = (r_state == ST_PLAY) && !r_last;
   assign w_rd_last    = w_rd && (r_rd_cnt == ADDR_W'(N-1));
   assign w_play_end   = (r_state == ST_PLAY) && r_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_LOAD;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_LOAD: if (w_wr_last)      w_next = ST_FULL;
         ST_FULL: if (enable_process) w_next = ST_PLAY;
         ST_PLAY: if (r_last)         w_next = ST_LOAD;
         default:                     w_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_last     <= 1'b0;
         frame_full <= 1'b0;
         finish     <= 1'b0;
         done       <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
      end else begin
         done <= 1'b0;
         if (w_wr) begin
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
            if (w_wr_last) frame_full <= 1'b1;
         end
         if (w_play_start) begin
            r_rd_cnt <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_last   <= 1'b0;
         end
         if (w_rd) begin
            // coordinates travel alongside the RAM read so they line up with out_r/g/b
            finish   <= 1'b1;
            out_x    <= r_x;
            out_y    <= r_y;
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (r_x == COORD_W'(IMG_WIDTH-1)) begin
               r_x <= '0;
               r_y <= r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
            if (w_rd_last) r_last <= 1'b1;
         end
         if (w_play_end) begin
            finish     <= 1'b0;
            done       <= 1'b1;
            frame_full <= 1'b0;
            r_last     <= 1'b0;
         end
      end
   end

`ifdef FRAME_CHECKSUM_EN
   localparam int CS_W = DEPTH + ADDR_W + 2;
   logic [CS_W-1:0] r_sum;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_sum <= '0;
      else if (w_play_end) r_sum <= '0;
      else if (w_wr)       r_sum <= r_sum + CS_W'(in_r) + CS_W'(in_g) + CS_W'(in_b);
   end
   assign checksum = r_sum;
`endif

   frame_ram #(
      .DW    (3*DEPTH),
      .WORDS (N),
      .AW    (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr),
      .i_waddr (r_wr_cnt),
      .i_wdata ({in_r, in_g, in_b}),
      .i_re    (w_rd),
      .i_raddr (r_rd_cnt),
      .o_rdata (w_rdata)
   );

   assign out_r = w_rdata[3*DEPTH-1:2*DEPTH];
   assign out_g = w_rdata[2*DEPTH-1:DEPTH];
   assign out_b = w_rdata[DEPTH-1:0];

endmodule

// File: doc/rgb_frame_buffer.md
Name: rgb_frame_buffer

Overview:
- Receiving end of the RGB pixel-stream load interface used by the face-detection filters. A producer drives one R/G/B pixel per cycle while `enable` is high.
- The block captures one raster-order frame into internal R/G/B memories.
- On `enable_process` it replays the frame in raster order with x/y coordinates and a valid strobe.
- It sits between the image source and any downstream filter (skin mask, centroid) that needs a whole frame before processing.

Parameters:
- IMG_WIDTH, 256, pixels per line.
- IMG_HEIGHT, 256, lines per frame.
- DEPTH, 8, bits per colour channel.
- ADDR_W, 16, address width; must satisfy 2**ADDR_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_r  in  DEPTH  red channel of the incoming pixel.
- in_g  in  DEPTH  green channel of the incoming pixel.
- in_b  in  DEPTH  blue channel of the incoming pixel.
- enable  in  1  load strobe; pixel accepted on each clk where it is high and state is LOAD.
- enable_process  in  1  level request to replay the stored frame.
- frame_full  out  1  high once all IMG_WIDTH*IMG_HEIGHT pixels are stored.
- out_r  out  DEPTH  replayed red channel.
- out_g  out  DEPTH  replayed green channel.
- out_b  out  DEPTH  replayed blue channel.
- out_x  out  9  column of the replayed pixel.
- out_y  out  9  row of the replayed pixel.
- finish  out  1  high exactly while out_* carry valid replay data.
- done  out  1  one-cycle pulse after the last replayed pixel.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port rst.
- Reset values: state=LOAD, wr_cnt=0, rd_cnt=0, frame_full=0, finish=0, done=0, out_r/g/b=0, out_x/out_y=0.
- Memory contents are not cleared by reset.
- States: LOAD -> FULL -> PLAY -> LOAD.
- LOAD:
  - Each cycle with enable=1, write in_r/g/b to address wr_cnt and increment wr_cnt.
  - On the write to address N-1 (N=IMG_WIDTH*IMG_HEIGHT), go to FULL, set frame_full=1 on the next cycle, and clear wr_cnt.
  - enable=0 stalls without a write; gaps are legal.
- FULL:
  - enable is ignored; no writes, no overflow.
  - When enable_process=1, go to PLAY with rd_cnt=0.
- PLAY:
  - Memory read is registered, so latency is 1 cycle from address issue to out_*.
  - The pixel at address k appears with finish=1 exactly k+1 cycles after PLAY entry.
  - One pixel per cycle, no gaps.
  - out_x = k mod IMG_WIDTH and out_y = k / IMG_WIDTH, both held in counters (no divider). out_x wraps to 0 and out_y increments at line end.
  - The cycle after pixel N-1: finish=0, done=1 for one cycle, frame_full=0, state=LOAD.
- enable_process dropped during PLAY: playback continues to completion (no pause).
- enable=1 during PLAY or FULL: ignored.
- enable and enable_process both high in LOAD: the write proceeds; the process request is ignored until FULL.
- Reset mid-LOAD or mid-PLAY: immediate return to reset values. A partial frame is discarded and the next load starts at address 0.
- out_r/g/b/x/y hold their last value when finish=0.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- When defined:
  - Adds output `checksum` (DEPTH+ADDR_W+2 bits): the sum of R+G+B over all accepted pixels.
  - Cleared by reset and on each LOAD entry.
  - Valid when frame_full=1 and held through PLAY.
- When undefined: the port and adder do not exist; other behaviour is identical.

Decomposition:
- Shared package `face_pkg` holds:
  - the state enum (LOAD, FULL, PLAY);
  - IMG_WIDTH/IMG_HEIGHT/DEPTH defaults;
  - the constant N_PIX;
  - the coordinate width 9.
- One sub-module, `frame_ram`: single write port plus single registered read port. It is instantiated three times (R, G, B), or once with width 3*DEPTH.

Test Plan:
- Load and replay: IMG_WIDTH=4, IMG_HEIGHT=4; load 16 pixels with R=k, G=2k, B=255-k, then enable_process=1 -> frame_full=1 after the 16th write. finish is high for 16 consecutive cycles, the first one cycle after PLAY entry, with out_r=k, out_x=k%4, out_y=k/4. done pulses once, 1 cycle after the last pixel.
- Gapped load: enable toggles 1,0,1,0 for 32 cycles -> exactly 16 writes, contents correct, frame_full rises only after the 16th accepted pixel.
- Overflow: 20 pixels driven continuously -> pixels 17-20 ignored; replay shows only the first 16.
- Early process: enable_process=1 held from cycle 0 during load -> no finish until the frame is full; playback starts on entry to FULL+1.
- Reset mid-PLAY: assert rst at pixel 7 of replay -> finish, frame_full, and out_x go to 0 immediately. A fresh 16-pixel load then replays from address 0 correctly.
- FRAME_CHECKSUM_EN: load all pixels R=G=B=1 at the 4x4 size -> checksum=48 at frame_full, held through PLAY.
